// File: rtl/gon_tag_sequencer.sv
// GON bus master: walks tags, collects beats into a 2-entry FWFT FIFO.
// Optional per-tag watchdog with sticky timeout_err under GON_TIMEOUT_EN.
`ifndef XID_BITS
`define XID_BITS 4
`endif

module gon_tag_sequencer #(
  parameter int ID_SIZE     = `XID_BITS,
  parameter int DATA_SIZE   = 64,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [ID_SIZE-1:0]   base_id,
  input  logic [ID_SIZE:0]     num_ids,
  input  logic [15:0]          num_passes,
  output logic [ID_SIZE-1:0]   gon_tag,
  output logic                 gon_ready,
  input  logic                 gon_valid,
  input  logic [DATA_SIZE-1:0] gon_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_SIZE-1:0] out_data,
  output logic [ID_SIZE-1:0]   out_tag,
  output logic                 busy,
  output logic                 done
`ifdef GON_TIMEOUT_EN
  ,
  output logic                 timeout_err
`endif
);

  localparam int EW = ID_SIZE + DATA_SIZE;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [ID_SIZE-1:0] tag_q, base_q;
  logic [ID_SIZE:0]   nids_q, id_cnt_q;
  logic [15:0]        npass_q, pass_cnt_q;

  logic [EW-1:0] mem_q [2];
  logic          rd_q, wr_q;
  logic [1:0]    cnt_q;
  logic [EW-1:0] head;

  logic fifo_full, fifo_empty;
  logic push, pop, skip, adv;
  logic start_acc, last_id, last_pass;

  assign fifo_full  = (cnt_q == 2'd2);
  assign fifo_empty = (cnt_q == 2'd0);
  assign gon_ready  = (state_q == S_COLLECT) && !fifo_full;
  assign push       = gon_valid && gon_ready;
  assign pop        = out_valid && out_ready;
  assign adv        = push || skip;
  assign start_acc  = (state_q == S_IDLE) && start;
  assign last_id    = ((id_cnt_q + 1'b1) == nids_q);
  assign last_pass  = ((pass_cnt_q + 16'd1) == npass_q);

  assign gon_tag   = tag_q;
  assign head      = mem_q[rd_q];
  assign out_valid = !fifo_empty;
  assign out_data  = out_valid ? head[DATA_SIZE-1:0] : '0;
  assign out_tag   = out_valid ? head[EW-1:DATA_SIZE] : '0;
  assign busy      = (state_q == S_COLLECT) || (state_q == S_DRAIN);
  assign done      = (state_q == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      state_q == S_IDLE: begin
        if (start) begin
          if (num_ids == '0 || num_passes == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_COLLECT;
          end
        end
      end
      state_q == S_COLLECT: begin
        if (adv && last_id && last_pass) begin
          state_d = S_DRAIN;
        end
      end
      state_q == S_DRAIN: begin
        if (fifo_empty) begin
          state_d = S_DONE;
        end
      end
      state_q == S_DONE: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Final pass leaves the tag at its last increment rather than reloading.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q      <= '0;
      base_q     <= '0;
      nids_q     <= '0;
      npass_q    <= '0;
      id_cnt_q   <= '0;
      pass_cnt_q <= '0;
    end else if (start_acc) begin
      tag_q      <= base_id;
      base_q     <= base_id;
      nids_q     <= num_ids;
      npass_q    <= num_passes;
      id_cnt_q   <= '0;
      pass_cnt_q <= '0;
    end else if (adv) begin
      if (last_id) begin
        id_cnt_q <= '0;
        if (last_pass) begin
          tag_q <= tag_q + 1'b1;
        end else begin
          tag_q      <= base_q;
          pass_cnt_q <= pass_cnt_q + 16'd1;
        end
      end else begin
        id_cnt_q <= id_cnt_q + 1'b1;
        tag_q    <= tag_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        mem_q[i] <= '0;
      end
      rd_q  <= 1'b0;
      wr_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= {tag_q, gon_data};
        wr_q        <= ~wr_q;
      end
      if (pop) begin
        rd_q <= ~rd_q;
      end
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

`ifdef GON_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam int WD_W = (CW > 8) ? CW : 8;

  logic [WD_W-1:0] wd_q;
  logic            idle_rdy;

  assign idle_rdy = gon_ready && !gon_valid;
  assign skip     = idle_rdy && (wd_q == WD_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q        <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (adv || state_q != S_COLLECT) begin
        wd_q <= '0;
      end else if (idle_rdy) begin
        wd_q <= wd_q + 1'b1;
      end
      if (start_acc) begin
        timeout_err <= 1'b0;
      end else if (skip) begin
        timeout_err <= 1'b1;
      end
    end
  end
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;
  assign skip = 1'b0;
`endif

endmodule

// File: tb/tb_gon_tag_sequencer.sv
// Directed bench for gon_tag_sequencer with ID_SIZE=4.
// Timeout scenario runs only when GON_TIMEOUT_EN is defined.
`timescale 1ns/1ps

module tb_gon_tag_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  base_id;
  logic [4:0]  num_ids;
  logic [15:0] num_passes;
  logic [3:0]  gon_tag;
  logic        gon_ready;
  logic        gon_valid;
  logic [63:0] gon_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [3:0]  out_tag;
  logic        busy;
  logic        done;
`ifdef GON_TIMEOUT_EN
  logic        timeout_err;
`endif

  logic        pe_en;
  logic        silent_en;
  logic [3:0]  silent_tag;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  function automatic logic [63:0] pe_data(input logic [3:0] t);
    return 64'hC0DE_F00D_0000_0000 | (64'(t) * 64'h0101);
  endfunction

  assign gon_valid = pe_en && !(silent_en && gon_tag == silent_tag);
  assign gon_data  = pe_data(gon_tag);

  gon_tag_sequencer #(
    .ID_SIZE(4),
    .DATA_SIZE(64),
    .TIMEOUT_CYC(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .base_id(base_id),
    .num_ids(num_ids),
    .num_passes(num_passes),
    .gon_tag(gon_tag),
    .gon_ready(gon_ready),
    .gon_valid(gon_valid),
    .gon_data(gon_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_tag(out_tag),
    .busy(busy),
    .done(done)
`ifdef GON_TIMEOUT_EN
    ,
    .timeout_err(timeout_err)
`endif
  );

  task automatic chk(input string name, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [3:0] b, input logic [4:0] n,
                          input logic [15:0] p);
    base_id    = b;
    num_ids    = n;
    num_passes = p;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      n++;
      if (done) break;
    end
    chk("done_seen", done, 1'b1);
  endtask

  initial begin
    int nc;
    logic [3:0] exp_tags [8];

    rst_n      = 1'b0;
    start      = 1'b0;
    base_id    = '0;
    num_ids    = '0;
    num_passes = '0;
    out_ready  = 1'b1;
    pe_en      = 1'b1;
    silent_en  = 1'b0;
    silent_tag = '0;

    tick();
    tick();
    chk("rst_gon_tag", gon_tag, 0);
    chk("rst_gon_ready", gon_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst_n = 1'b1;
    tick();

    // Basic pass: tags 3..6
    do_start(4'd3, 5'd4, 16'd1);
    chk("t1_busy", busy, 1);
    chk("t1_ready", gon_ready, 1);
    for (int i = 0; i < 4; i++) begin
      chk("t1_tag", gon_tag, 4'(3 + i));
      tick();
      chk("t1_out_tag", out_tag, 4'(3 + i));
      chk("t1_out_data", out_data, pe_data(4'(3 + i)));
    end
    chk("t1_done_e", done, 0);
    tick();
    chk("t1_drained", out_valid, 0);
    chk("t1_done_e1", done, 0);
    tick();
    chk("t1_done", done, 1);
    chk("t1_busy_off", busy, 0);
    chk("t1_tag_hold", gon_tag, 7);
    tick();
    chk("t1_done_pulse", done, 0);

    // Wrap past max ID, two passes
    exp_tags = '{4'd14, 4'd15, 4'd0, 4'd1, 4'd14, 4'd15, 4'd0, 4'd1};
    do_start(4'd14, 5'd4, 16'd2);
    for (int i = 0; i < 8; i++) begin
      chk("t2_tag", gon_tag, exp_tags[i]);
      tick();
      chk("t2_out_tag", out_tag, exp_tags[i]);
    end
    chk("t2_tag_hold", gon_tag, 2);
    wait_done(nc);
    chk("t2_done_lat", nc, 2);
    tick();

    // Backpressure
    out_ready = 1'b0;
    do_start(4'd8, 5'd4, 16'd1);
    chk("t3_tag0", gon_tag, 8);
    tick();
    chk("t3_tag1", gon_tag, 9);
    tick();
    chk("t3_full_ready", gon_ready, 0);
    chk("t3_full_tag", gon_tag, 10);
    tick();
    tick();
    chk("t3_stall_ready", gon_ready, 0);
    chk("t3_stall_tag", gon_tag, 10);
    chk("t3_stall_head", out_tag, 8);
    out_ready = 1'b1;
    tick();
    chk("t3_a_head", out_tag, 9);
    chk("t3_a_ready", gon_ready, 1);
    chk("t3_a_tag", gon_tag, 10);
    tick();
    chk("t3_b_head", out_tag, 10);
    chk("t3_b_tag", gon_tag, 11);
    tick();
    chk("t3_c_head", out_tag, 11);
    chk("t3_c_ready", gon_ready, 0);
    chk("t3_c_busy", busy, 1);
    tick();
    chk("t3_d_empty", out_valid, 0);
    tick();
    chk("t3_done", done, 1);
    tick();

    // Zero-length starts
    do_start(4'd5, 5'd0, 16'd3);
    chk("t4_done_ids0", done, 1);
    chk("t4_busy_ids0", busy, 0);
    chk("t4_ready_ids0", gon_ready, 0);
    tick();
    chk("t4_done_off", done, 0);
    do_start(4'd5, 5'd2, 16'd0);
    chk("t4_done_pass0", done, 1);
    chk("t4_ready_pass0", gon_ready, 0);
    tick();

    // Start while busy is ignored
    pe_en = 1'b0;
    do_start(4'd0, 5'd3, 16'd1);
    chk("t4b_busy", busy, 1);
    chk("t4b_tag", gon_tag, 0);
    do_start(4'd9, 5'd1, 16'd1);
    chk("t4b_ign_tag", gon_tag, 0);
    chk("t4b_ign_ready", gon_ready, 1);
    pe_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4b_out_tag", out_tag, 4'(i));
    end
    chk("t4b_cfg_kept", busy, 1);
    wait_done(nc);
    chk("t4b_done_lat", nc, 2);
    tick();

    // Reset with one FIFO entry pending
    out_ready = 1'b0;
    do_start(4'd5, 5'd4, 16'd1);
    tick();
    pe_en = 1'b0;
    chk("t5_pending", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", out_valid, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_tag", gon_tag, 0);
    tick();
    rst_n     = 1'b1;
    pe_en     = 1'b1;
    out_ready = 1'b1;
    tick();
    do_start(4'd5, 5'd2, 16'd1);
    chk("t5_restart_tag", gon_tag, 5);
    tick();
    chk("t5_out0", out_tag, 5);
    tick();
    chk("t5_out1", out_tag, 6);
    wait_done(nc);
    chk("t5_done_lat", nc, 2);
    tick();

`ifdef GON_TIMEOUT_EN
    // Silent PE at tag 5
    silent_en  = 1'b1;
    silent_tag = 4'd5;
    do_start(4'd3, 5'd4, 16'd1);
    tick();
    tick();
    chk("t6_at5", gon_tag, 5);
    chk("t6_err0", timeout_err, 0);
    for (int i = 0; i < 15; i++) begin
      tick();
    end
    chk("t6_still5", gon_tag, 5);
    chk("t6_err_pre", timeout_err, 0);
    tick();
    chk("t6_skipped", gon_tag, 6);
    chk("t6_err_set", timeout_err, 1);
    tick();
    chk("t6_out6", out_tag, 6);
    wait_done(nc);
    chk("t6_err_sticky", timeout_err, 1);
    tick();
    silent_en = 1'b0;
    do_start(4'd1, 5'd1, 16'd1);
    chk("t6_err_clr", timeout_err, 0);
    wait_done(nc);
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "bench timeout");
  end

endmodule
